// File: rtl/vga_mode_sequencer.sv
// rtl/vga_mode_sequencer.sv - button debounce, frame-synchronous pattern/blank control and status LEDs
// Automatic pattern cycling is enabled by defining VGA_MODE_SEQ_AUTO_CYCLE_EN.
module vga_mode_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NUM_PATTERNS    = 4,
    parameter int AUTO_FRAMES     = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_pause,
    input  logic       btn_blank,
    input  logic       v_sync,
    output logic [1:0] pattern_sel,
    output logic       blank,
    output logic       paused,
    output logic       pending,
    output logic [4:0] led
);
    localparam int              DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]      PAT_LAST = 2'(NUM_PATTERNS - 1);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_APPLY = 2'd2;

    localparam logic [1:0] DIR_NONE = 2'd0;
    localparam logic [1:0] DIR_NEXT = 2'd1;
    localparam logic [1:0] DIR_PREV = 2'd2;

    // Bit order: 0 next, 1 prev, 2 pause, 3 blank
    logic [3:0]            btn_raw;
    logic [3:0]            btn_s1_q, btn_s2_q, btn_lvl_q, btn_lvl_d, press_q, press_d;
    logic [3:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic                  vs_s1_q, vs_s2_q, vs_dly_q, fb_q;
    logic [1:0]            state_q, state_d, pattern_q, pattern_d;
    logic [1:0]            dir_q, dir_d, dir_raw;
    logic                  tog_q, tog_d, tog_raw;
    logic                  blank_q, blank_d, paused_q;
    logic                  auto_fire, enter_apply;

    assign btn_raw = {btn_blank, btn_pause, btn_prev, btn_next};

    function automatic logic [1:0] step_pattern(input logic [1:0] p, input logic [1:0] dir);
        step_pattern = p;
        if (dir == DIR_NEXT) begin
            step_pattern = (p == PAT_LAST) ? 2'd0 : p + 2'd1;
        end else if (dir == DIR_PREV) begin
            step_pattern = (p == 2'd0) ? PAT_LAST : p - 2'd1;
        end
    endfunction

    always_comb begin
        btn_lvl_d = btn_lvl_q;
        press_d   = '0;
        db_cnt_d  = '0;
        for (int i = 0; i < 4; i++) begin
            if (btn_s2_q[i] != btn_lvl_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    btn_lvl_d[i] = btn_s2_q[i];
                    press_d[i]   = btn_s2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Simultaneous next+prev is ignored; an opposite press cancels a pending step.
    always_comb begin
        dir_raw = dir_q;
        if (press_q[0] && !press_q[1]) begin
            dir_raw = (dir_q == DIR_PREV) ? DIR_NONE : DIR_NEXT;
        end else if (press_q[1] && !press_q[0]) begin
            dir_raw = (dir_q == DIR_NEXT) ? DIR_NONE : DIR_PREV;
        end
        tog_raw = tog_q ^ press_q[3];
    end

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_raw;
        tog_d       = tog_raw;
        pattern_d   = pattern_q;
        blank_d     = blank_q;
        enter_apply = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (dir_raw != DIR_NONE || tog_raw) begin
                    state_d = ST_ARMED;
                end else if (auto_fire) begin
                    state_d     = ST_APPLY;
                    enter_apply = 1'b1;
                    pattern_d   = step_pattern(pattern_q, DIR_NEXT);
                end
            end
            ST_ARMED: begin
                if (dir_raw == DIR_NONE && !tog_raw) begin
                    state_d = ST_RUN;
                end else if (fb_q) begin
                    state_d     = ST_APPLY;
                    enter_apply = 1'b1;
                    pattern_d   = step_pattern(pattern_q, dir_raw);
                    blank_d     = blank_q ^ tog_raw;
                    dir_d       = DIR_NONE;
                    tog_d       = 1'b0;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

`ifdef VGA_MODE_SEQ_AUTO_CYCLE_EN
    localparam int              FC_W    = $clog2(AUTO_FRAMES + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(AUTO_FRAMES - 1);

    logic [FC_W-1:0] fc_q, fc_d;
    logic            auto_tick;

    assign auto_tick = fb_q && !paused_q && !blank_q && (state_q == ST_RUN);
    assign auto_fire = auto_tick && (fc_q == FC_LAST);

    // At the last count the counter clears even when a manual request pre-empts the step.
    always_comb begin
        fc_d = fc_q;
        if (enter_apply || (auto_tick && fc_q == FC_LAST)) begin
            fc_d = '0;
        end else if (auto_tick) begin
            fc_d = fc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fc_q <= '0;
        end else begin
            fc_q <= fc_d;
        end
    end
`else
    assign auto_fire = 1'b0 & (AUTO_FRAMES > 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_s1_q  <= '0;
            btn_s2_q  <= '0;
            btn_lvl_q <= '0;
            press_q   <= '0;
            db_cnt_q  <= '0;
            vs_s1_q   <= 1'b1;
            vs_s2_q   <= 1'b1;
            vs_dly_q  <= 1'b1;
            fb_q      <= 1'b0;
            state_q   <= ST_RUN;
            pattern_q <= 2'd0;
            dir_q     <= DIR_NONE;
            tog_q     <= 1'b0;
            blank_q   <= 1'b0;
            paused_q  <= 1'b0;
        end else begin
            btn_s1_q  <= btn_raw;
            btn_s2_q  <= btn_s1_q;
            btn_lvl_q <= btn_lvl_d;
            press_q   <= press_d;
            db_cnt_q  <= db_cnt_d;
            vs_s1_q   <= v_sync;
            vs_s2_q   <= vs_s1_q;
            vs_dly_q  <= vs_s2_q;
            fb_q      <= vs_dly_q & ~vs_s2_q;
            state_q   <= state_d;
            pattern_q <= pattern_d;
            dir_q     <= dir_d;
            tog_q     <= tog_d;
            blank_q   <= blank_d;
            paused_q  <= paused_q ^ press_q[2];
        end
    end

    assign pattern_sel = pattern_q;
    assign blank       = blank_q;
    assign paused      = paused_q;
    assign pending     = (state_q == ST_ARMED);
    assign led         = {paused_q, pattern_q == 2'd3, pattern_q == 2'd2,
                          pattern_q == 2'd1, pattern_q == 2'd0};
endmodule
